sipo_deserializer_framed: RTL and testbench
===========================================

# sipo_deserializer_framed

Parametrised serial-to-parallel deserializer, the successor to the fixed 32-bit SIPO shift register. It collects qualified serial bits into WIDTH-bit words with selectable bit order and optional frame realignment. Each completed word is presented through a one-entry holding register with a valid/ready handshake. It sits between a serial receive front end (link or sensor bit stream, no backpressure) and word-oriented downstream logic.

## Interface
- WIDTH, 32, data word width in bits; legal range 2..64
- MSB_FIRST, 1, 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0
- PARITY_ODD, 0, parity sense when parity is compiled in; 0 = even, 1 = odd; ignored otherwise

Ports:
- Clk_In  input  1  clock; all state updates on the rising edge
- Reset_In  input  1  asynchronous, active-high reset
- Serial_Data_In  input  1  serial bit; sampled only when Serial_Valid_In = 1
- Serial_Valid_In  input  1  qualifies Serial_Data_In for this cycle
- Frame_Start_In  input  1  realigns the bit counter to the start of a word
- Parallel_Data_Out  output  WIDTH  completed word from the holding register
- Parallel_Valid_Out  output  1  holding register occupied
- Parallel_Ready_In  input  1  downstream accepts the word when Valid and Ready are both 1
- Busy_Out  output  1  partial word in progress (bit count ≠ 0, or in parity state)
- Overflow_Out  output  1  sticky: a completed word was dropped
- Overflow_Clear_In  input  1  clears Overflow_Out
- Parity_Error_Out  output  1  parity mismatch for the word currently held; meaningful while Parallel_Valid_Out = 1

## Operation
- Shift register (WIDTH bits) and bit counter Bit_Count (0..WIDTH-1) accumulate bits.
- MSB_FIRST=1: shift left, new bit enters bit 0. MSB_FIRST=0: shift right, new bit enters bit WIDTH-1.
- States: S_DATA (collecting data bits) and S_PARITY (waiting for the parity bit; present only with the macro).
- In S_DATA, each valid bit increments Bit_Count. The bit taken at Bit_Count = WIDTH-1 completes the data. Without parity, the word completes on that bit. With parity, the FSM enters S_PARITY.
- In S_PARITY, the next valid bit is the parity bit. The word completes on that bit, and the FSM returns to S_DATA with Bit_Count = 0.
- Word completion behaviour:
  - If the holding register is empty, or is being drained in the same cycle (Valid & Ready), the word is loaded and Parallel_Valid_Out becomes 1.
  - Otherwise the new word is dropped, the held word is kept unchanged, and Overflow_Out is set to 1.
- A handshake (Valid & Ready) without a new completion clears Parallel_Valid_Out.
- Frame_Start_In = 1 discards any partial word and returns the FSM to S_DATA.
  - With Serial_Valid_In = 1 in the same cycle, that bit becomes bit 0 of the new word (Bit_Count → 1).
  - Without it, Bit_Count → 0.
- Overflow_Clear_In clears Overflow_Out. If an overflow occurs in the same cycle, set wins.

## Timing
- Reset values: Parallel_Data_Out = 0, Parallel_Valid_Out = 0, Busy_Out = 0, Overflow_Out = 0, Parity_Error_Out = 0. Shift register = 0, Bit_Count = 0, state = S_DATA.
- Latency: Parallel_Valid_Out rises on the clock edge that samples the completing bit, i.e. it is visible the cycle after that bit is presented.
- Throughput: one bit per cycle; back-to-back words need no gap.
- Parallel_Data_Out and Parity_Error_Out change only on a load edge and are stable while Valid = 1 and Ready = 0.
- Reset asserted mid-word or mid-handshake aborts everything immediately. The partial word and the held word are both lost.

## Configuration
- SIPO_PARITY_EN defined:
  - S_PARITY exists and each word takes WIDTH+1 bits.
  - The received parity bit is compared with the XOR of the data bits, inverted when PARITY_ODD = 1.
  - A mismatch sets Parity_Error_Out together with the loaded word. The word is still delivered.
- SIPO_PARITY_EN undefined:
  - Each word takes WIDTH bits and there is no S_PARITY.
  - Parity_Error_Out is tied to 0 and PARITY_ODD is unused.

## Structure
- Shared package sipo_pkg:
  - state enum (S_DATA, S_PARITY)
  - counter-width function returning max(1, $clog2(WIDTH))
  - default parameter constants
- One sub-module, sipo_holding_register: WIDTH+1-bit payload (data + parity error), load/drain handshake, overflow detection and the sticky overflow flag.
- The top level holds the shifter, the counter and the FSM.

## Test plan
- WIDTH=8, MSB_FIRST=1: send bits 1,0,1,0,0,1,0,1 on consecutive cycles with Ready=1 → Parallel_Data_Out = 8'hA5 with Valid high one cycle after the 8th bit; handshake then drops Valid.
- WIDTH=8, MSB_FIRST=0: send the same bit sequence → Parallel_Data_Out = 8'hA5 bit-reversed = 8'hA5; then send 1,1,0,0,0,0,0,0 → 8'h03.
- Ready=0: send 8'h11 then 8'h22 → held word stays 8'h11, Overflow_Out = 1. Pulse Overflow_Clear_In → Overflow_Out = 0. Raise Ready → 8'h11 is accepted.
- Ready held low until the cycle the second word completes, then Ready=1 → 8'h11 is drained, 8'h22 is loaded, Overflow_Out stays 0.
- Frame_Start_In after 3 bits, followed by 8 fresh bits of 8'h3C → output 8'h3C. Reset asserted after 5 bits → all outputs 0 and the next full word decodes correctly.
- SIPO_PARITY_EN, PARITY_ODD=0: 8'hA5 + parity bit 0 → Parity_Error_Out = 0. 8'hA5 + parity bit 1 → Parity_Error_Out = 1 and the data is still 8'hA5.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and constants for the framed SIPO deserializer.
// The optional parity stage is controlled by the SIPO_PARITY_EN macro.
package sipo_pkg;

   typedef enum logic {
      S_DATA,
      S_PARITY
   } sipo_state_e;

   localparam int unsigned DefWidth     = 32;
   localparam int unsigned DefMsbFirst  = 1;
   localparam int unsigned DefParityOdd = 0;

   // Bit counter width: max(1, clog2(width)).
   function automatic int unsigned cnt_width(input int unsigned width);
      if ($clog2(width) < 1) begin
         return 1;
      end
      return $clog2(width);
   endfunction

endpackage

// File: rtl/sipo_deserializer_framed_if.sv
// Serial input, parallel handshake output and status bundle for the deserializer.
interface sipo_deserializer_framed_if #(
   parameter int unsigned WIDTH = 32
);
   logic             Serial_Data_In;
   logic             Serial_Valid_In;
   logic             Frame_Start_In;
   logic [WIDTH-1:0] Parallel_Data_Out;
   logic             Parallel_Valid_Out;
   logic             Parallel_Ready_In;
   logic             Busy_Out;
   logic             Overflow_Out;
   logic             Overflow_Clear_In;
   logic             Parity_Error_Out;

   modport slave (
      input  Serial_Data_In,
      input  Serial_Valid_In,
      input  Frame_Start_In,
      input  Parallel_Ready_In,
      input  Overflow_Clear_In,
      output Parallel_Data_Out,
      output Parallel_Valid_Out,
      output Busy_Out,
      output Overflow_Out,
      output Parity_Error_Out
   );

   modport master (
      output Serial_Data_In,
      output Serial_Valid_In,
      output Frame_Start_In,
      output Parallel_Ready_In,
      output Overflow_Clear_In,
      input  Parallel_Data_Out,
      input  Parallel_Valid_Out,
      input  Busy_Out,
      input  Overflow_Out,
      input  Parity_Error_Out
   );
endinterface

// File: rtl/sipo_holding_register.sv
// One-entry output buffer with valid/ready handshake and sticky overflow flag.
module sipo_holding_register #(
   parameter int unsigned PayloadW = 33
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic [PayloadW-1:0] payload_i,
   input  logic                ready_i,
   input  logic                clear_i,
   output logic [PayloadW-1:0] payload_o,
   output logic                valid_o,
   output logic                overflow_o
);

   logic [PayloadW-1:0] payload_q, payload_d;
   logic                valid_q, valid_d;
   logic                overflow_q, overflow_d;
   logic                drain;
   logic                drop;

   always_comb begin
      payload_d  = payload_q;
      valid_d    = valid_q;
      drop       = 1'b0;
      drain      = valid_q & ready_i;
      if (load_i) begin
         if (!valid_q || drain) begin
            payload_d = payload_i;
            valid_d   = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end else if (drain) begin
         valid_d = 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      overflow_d = (overflow_q & ~clear_i) | drop;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         payload_q  <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         payload_q  <= payload_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign payload_o  = payload_q;
   assign valid_o    = valid_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/sipo_deserializer_framed.sv
// Framed serial-to-parallel deserializer: shifter, bit counter and word FSM.
// Define SIPO_PARITY_EN to append and check a parity bit after each word.
module sipo_deserializer_framed
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH      = DefWidth,
   parameter int unsigned MSB_FIRST  = DefMsbFirst,
   parameter int unsigned PARITY_ODD = DefParityOdd
) (
   input logic                    Clk_In,
   input logic                    Reset_In,
   sipo_deserializer_framed_if.slave bus
);

   localparam int unsigned    CntW    = cnt_width(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             complete;
   logic [WIDTH:0]   payload;
   logic [WIDTH:0]   hold;
`ifdef SIPO_PARITY_EN
   sipo_state_e      state_q, state_d;
`endif

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
      if (MSB_FIRST != 0) begin
         return {cur[WIDTH-2:0], b};
      end
      return {b, cur[WIDTH-1:1]};
   endfunction

   always_comb begin
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      complete = 1'b0;
      payload  = '0;
`ifdef SIPO_PARITY_EN
      state_d  = state_q;
`endif
      if (bus.Frame_Start_In) begin
         cnt_d   = bus.Serial_Valid_In ? CntW'(1) : '0;
         shift_d = bus.Serial_Valid_In ? shift_in('0, bus.Serial_Data_In) : '0;
`ifdef SIPO_PARITY_EN
         state_d = S_DATA;
`endif
      end else if (bus.Serial_Valid_In) begin
`ifdef SIPO_PARITY_EN
         if (state_q == S_PARITY) begin
            complete = 1'b1;
            payload  = {((^shift_q) ^ (PARITY_ODD != 0)) != bus.Serial_Data_In, shift_q};
            state_d  = S_DATA;
         end else begin
            shift_d = shift_in(shift_q, bus.Serial_Data_In);
            if (cnt_q == LastCnt) begin
               cnt_d   = '0;
               state_d = S_PARITY;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
`else
         shift_d = shift_in(shift_q, bus.Serial_Data_In);
         if (cnt_q == LastCnt) begin
            cnt_d    = '0;
            complete = 1'b1;
            payload  = {1'b0, shift_d};
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
`endif
      end
   end

   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         shift_q <= '0;
         cnt_q   <= '0;
`ifdef SIPO_PARITY_EN
         state_q <= S_DATA;
`endif
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
`ifdef SIPO_PARITY_EN
         state_q <= state_d;
`endif
      end
   end

   sipo_holding_register #(
      .PayloadW(WIDTH + 1)
   ) u_hold (
      .clk_i     (Clk_In),
      .rst_i     (Reset_In),
      .load_i    (complete),
      .payload_i (payload),
      .ready_i   (bus.Parallel_Ready_In),
      .clear_i   (bus.Overflow_Clear_In),
      .payload_o (hold),
      .valid_o   (bus.Parallel_Valid_Out),
      .overflow_o(bus.Overflow_Out)
   );

   assign bus.Parallel_Data_Out = hold[WIDTH-1:0];
   // Without parity the error bit is only ever loaded as 0, so this is constant 0.
   assign bus.Parity_Error_Out  = hold[WIDTH];

`ifdef SIPO_PARITY_EN
   assign bus.Busy_Out = (cnt_q != '0) || (state_q == S_PARITY);
`else
   assign bus.Busy_Out = (cnt_q != '0);
`endif

endmodule

// File: tb/tb_sipo_deserializer_framed.sv
// Directed bench for sipo_deserializer_framed: an MSB-first and an LSB-first instance side by side.
module tb_sipo_deserializer_framed;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

`ifdef SIPO_PARITY_EN
   localparam bit Par = 1'b1;
`else
   localparam bit Par = 1'b0;
`endif

   sipo_deserializer_framed_if #(.WIDTH(8)) ifm ();
   sipo_deserializer_framed_if #(.WIDTH(8)) ifl ();

   sipo_deserializer_framed #(
      .WIDTH(8), .MSB_FIRST(1), .PARITY_ODD(0)
   ) u_msb (
      .Clk_In  (clk),
      .Reset_In(rst),
      .bus     (ifm)
   );

   sipo_deserializer_framed #(
      .WIDTH(8), .MSB_FIRST(0), .PARITY_ODD(0)
   ) u_lsb (
      .Clk_In  (clk),
      .Reset_In(rst),
      .bus     (ifl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] seq;      // seq[7] is sent first
      logic [7:0] exp_msb;
      logic [7:0] exp_lsb;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic d, input logic fs);
      ifm.Serial_Valid_In = v;
      ifm.Serial_Data_In  = d;
      ifm.Frame_Start_In  = fs;
      ifl.Serial_Valid_In = v;
      ifl.Serial_Data_In  = d;
      ifl.Frame_Start_In  = fs;
   endtask

   task automatic set_ready(input logic r);
      ifm.Parallel_Ready_In = r;
      ifl.Parallel_Ready_In = r;
   endtask

   task automatic set_clear(input logic c);
      ifm.Overflow_Clear_In = c;
      ifl.Overflow_Clear_In = c;
   endtask

   // Sends one word (plus even parity, optionally flipped, when parity is built in) and
   // returns at the falling edge after the completing bit was sampled.
   task automatic send_word(input logic [7:0] seq, input bit fs_first, input bit ready_last,
                            input bit par_flip);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         drive(1'b1, seq[i], fs_first && (i == 7));
         if (ready_last && !Par && i == 0) set_ready(1'b1);
      end
      if (Par) begin
         @(negedge clk);
         drive(1'b1, (^seq) ^ par_flip, 1'b0);
         if (ready_last) set_ready(1'b1);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      vecs[0] = '{seq: 8'hA5, exp_msb: 8'hA5, exp_lsb: 8'hA5};
      vecs[1] = '{seq: 8'hC0, exp_msb: 8'hC0, exp_lsb: 8'h03};
      vecs[2] = '{seq: 8'h3C, exp_msb: 8'h3C, exp_lsb: 8'h3C};
      vecs[3] = '{seq: 8'h80, exp_msb: 8'h80, exp_lsb: 8'h01};
      vecs[4] = '{seq: 8'h12, exp_msb: 8'h12, exp_lsb: 8'h48};
      vecs[5] = '{seq: 8'hF0, exp_msb: 8'hF0, exp_lsb: 8'h0F};

      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      set_ready(1'b0);
      set_clear(1'b0);
      repeat (2) @(negedge clk);
      chk("reset_valid", ifm.Parallel_Valid_Out, 0);
      chk("reset_data", ifm.Parallel_Data_Out, 0);
      chk("reset_busy", ifm.Busy_Out, 0);
      chk("reset_ovf", ifm.Overflow_Out, 0);
      chk("reset_perr", ifm.Parity_Error_Out, 0);
      rst = 1'b0;

      // Table: one word at a time with Ready held high.
      set_ready(1'b1);
      for (int k = 0; k < 6; k++) begin
         send_word(vecs[k].seq, 1'b0, 1'b0, 1'b0);
         chk($sformatf("vec%0d_valid", k), ifm.Parallel_Valid_Out, 1);
         chk($sformatf("vec%0d_msb", k), ifm.Parallel_Data_Out, vecs[k].exp_msb);
         chk($sformatf("vec%0d_lsb", k), ifl.Parallel_Data_Out, vecs[k].exp_lsb);
         chk($sformatf("vec%0d_perr", k), ifm.Parity_Error_Out, 0);
         @(negedge clk);
         chk($sformatf("vec%0d_drained", k), ifm.Parallel_Valid_Out, 0);
      end

      // Overflow: second word dropped while the first is held.
      set_ready(1'b0);
      send_word(8'h11, 1'b0, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0, 1'b0);
      chk("ovf_data", ifm.Parallel_Data_Out, 8'h11);
      chk("ovf_valid", ifm.Parallel_Valid_Out, 1);
      chk("ovf_flag", ifm.Overflow_Out, 1);
      chk("ovf_lsb_data", ifl.Parallel_Data_Out, 8'h88);
      set_clear(1'b1);
      @(negedge clk);
      set_clear(1'b0);
      chk("ovf_cleared", ifm.Overflow_Out, 0);
      chk("ovf_data_kept", ifm.Parallel_Data_Out, 8'h11);
      set_ready(1'b1);
      @(negedge clk);
      chk("ovf_accepted", ifm.Parallel_Valid_Out, 0);

      // Drain and load on the same edge: no overflow.
      set_ready(1'b0);
      send_word(8'h11, 1'b0, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b1, 1'b0);
      chk("swap_data", ifm.Parallel_Data_Out, 8'h22);
      chk("swap_valid", ifm.Parallel_Valid_Out, 1);
      chk("swap_ovf", ifm.Overflow_Out, 0);
      @(negedge clk);
      chk("swap_drained", ifm.Parallel_Valid_Out, 0);

      // Frame start with a valid bit after 3 stray bits.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, 1'b0);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
      chk("frame_busy", ifm.Busy_Out, 1);
      send_word(8'h3C, 1'b1, 1'b0, 1'b0);
      chk("frame_valid", ifm.Parallel_Valid_Out, 1);
      chk("frame_msb", ifm.Parallel_Data_Out, 8'h3C);
      chk("frame_lsb", ifl.Parallel_Data_Out, 8'h3C);
      @(negedge clk);

      // Frame start alone clears the partial word.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 1'b0);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
      chk("fs_only_busy", ifm.Busy_Out, 0);

      // Reset mid-word with a held word and overflow pending.
      set_ready(1'b0);
      send_word(8'hA5, 1'b0, 1'b0, 1'b0);
      send_word(8'h3C, 1'b0, 1'b0, 1'b0);
      for (int i = 7; i >= 3; i--) begin
         @(negedge clk);
         drive(1'b1, 1'b1, 1'b0);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
      chk("pre_rst_ovf", ifm.Overflow_Out, 1);
      rst = 1'b1;
      #1;
      chk("rst_valid", ifm.Parallel_Valid_Out, 0);
      chk("rst_data", ifm.Parallel_Data_Out, 0);
      chk("rst_busy", ifm.Busy_Out, 0);
      chk("rst_ovf", ifm.Overflow_Out, 0);
      @(negedge clk);
      rst = 1'b0;
      set_ready(1'b1);
      send_word(8'hF0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_msb", ifm.Parallel_Data_Out, 8'hF0);
      chk("post_rst_lsb", ifl.Parallel_Data_Out, 8'h0F);
      chk("post_rst_valid", ifm.Parallel_Valid_Out, 1);
      @(negedge clk);

`ifdef SIPO_PARITY_EN
      send_word(8'hA5, 1'b0, 1'b0, 1'b0);
      chk("par_ok_perr", ifm.Parity_Error_Out, 0);
      chk("par_ok_data", ifm.Parallel_Data_Out, 8'hA5);
      @(negedge clk);
      send_word(8'hA5, 1'b0, 1'b0, 1'b1);
      chk("par_bad_perr", ifm.Parity_Error_Out, 1);
      chk("par_bad_data", ifm.Parallel_Data_Out, 8'hA5);
      chk("par_bad_valid", ifm.Parallel_Valid_Out, 1);
      @(negedge clk);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
